// File: rtl/vga_pkg.sv
// Shared timing defaults (640x480@60) and region-decode helpers for the VGA timing generator.
package vga_pkg;

    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Half-open interval test: lo <= v < hi.
    function automatic logic in_region(input int v, input int lo, input int hi);
        return (v >= lo) && (v < hi);
    endfunction

    // Display region starts at count 0.
    function automatic logic is_active(input int cnt, input int display);
        return cnt < display;
    endfunction

    // Sync pulse sits after display and front porch.
    function automatic logic is_sync(input int cnt, input int display, input int front,
                                     input int sync);
        return in_region(cnt, display + front, display + front + sync);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping counter plus display/sync region decode.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int DISPLAY = DEF_H_DISPLAY,
    parameter int FRONT   = DEF_H_FRONT,
    parameter int SYNC    = DEF_H_SYNC,
    parameter int BACK    = DEF_H_BACK,
    localparam int TOTAL  = DISPLAY + FRONT + SYNC + BACK,
    localparam int W      = $clog2(TOTAL)
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         CE,
    output logic [W-1:0] CNT,
    output logic         ACTIVE,
    output logic         IN_SYNC,
    output logic         WRAP
);

    if (DISPLAY < 1 || SYNC < 1 || FRONT < 0 || BACK < 0) begin : g_bad_timing
        $error("vga_axis_counter: DISPLAY and SYNC must be >= 1, porches >= 0");
    end

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    assign WRAP    = (CNT == LAST);
    assign ACTIVE  = is_active(int'(CNT), DISPLAY);
    assign IN_SYNC = is_sync(int'(CNT), DISPLAY, FRONT, SYNC);

    // Count on each enabled tick, wrapping from TOTAL-1 back to 0.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            CNT <= '0;
        end else if (CE) begin
            CNT <= WRAP ? '0 : CNT + 1'b1;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: H/V axis counters, registered sync/colour outputs, upstream strobes.
// Upstream handshake: PIXEL_EN acts as "valid-and-ready" in one; the source must present
// PIXEL for (X,Y) combinationally in that cycle and advance its pointer on PIXEL_EN.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int COLOR_W   = 8,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               CE,
    input  logic [COLOR_W-1:0] PIXEL,
    output logic               HSYNC,
    output logic               VSYNC,
    output logic [COLOR_W-1:0] COLOR,
    output logic               PIXEL_EN,
    output logic [HW-1:0]      X,
    output logic [VW-1:0]      Y,
    output logic               LINE_START,
    output logic               FRAME_START
);

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          h_active, h_sync, h_wrap;
    logic          v_active, v_sync, v_wrap_unused;
    logic          v_ce;

    assign v_ce = CE & h_wrap;

    vga_axis_counter #(
        .DISPLAY(H_DISPLAY), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK)
    ) u_h (
        .CLK(CLK), .RESET(RESET), .CE(CE),
        .CNT(h_cnt), .ACTIVE(h_active), .IN_SYNC(h_sync), .WRAP(h_wrap)
    );

    vga_axis_counter #(
        .DISPLAY(V_DISPLAY), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK)
    ) u_v (
        .CLK(CLK), .RESET(RESET), .CE(v_ce),
        .CNT(v_cnt), .ACTIVE(v_active), .IN_SYNC(v_sync), .WRAP(v_wrap_unused)
    );

    // Strobes lead the registered video outputs by one tick; all are gated by CE.
    assign X           = h_cnt;
    assign Y           = v_cnt;
    assign PIXEL_EN    = CE & h_active & v_active;
    assign LINE_START  = CE & (h_cnt == '0);
    assign FRAME_START = CE & (h_cnt == '0) & (v_cnt == '0);

    // Register sync and colour together so they leave the block aligned.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            HSYNC <= ~H_SYNC_POL;
            VSYNC <= ~V_SYNC_POL;
            COLOR <= '0;
        end else if (CE) begin
            HSYNC <= h_sync ? H_SYNC_POL : ~H_SYNC_POL;
            VSYNC <= v_sync ? V_SYNC_POL : ~V_SYNC_POL;
            COLOR <= (h_active && v_active) ? PIXEL : '0;
        end
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised VGA timing generator and pixel gate. It is the successor of the fixed-geometry sync/pixel block.
- All horizontal and vertical timings, sync polarities and colour width are parameters.
- Exports pixel coordinates and line/frame start strobes.
- Registers its video outputs so HSYNC, VSYNC and COLOR leave aligned.
- Sits between the framebuffer/pixel source (upstream, driven by PIXEL_EN/X/Y) and the DAC/pins (downstream).

Parameters:
COLOR_W, 8, width of PIXEL and COLOR
H_DISPLAY, 640, active pixels per line
H_FRONT, 16, horizontal front porch (ticks)
H_SYNC, 96, horizontal sync pulse (ticks)
H_BACK, 48, horizontal back porch (ticks)
V_DISPLAY, 480, active lines per frame
V_FRONT, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync pulse (lines)
V_BACK, 33, vertical back porch (lines)
H_SYNC_POL, 0, HSYNC active level (0 = active-low)
V_SYNC_POL, 0, VSYNC active level (0 = active-low)
Derived constants: H_TOTAL = sum of the four H values; V_TOTAL likewise; HW = $clog2(H_TOTAL); VW = $clog2(V_TOTAL).

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
CE  in  1  pixel tick enable; all timing advances only when CE=1
PIXEL  in  COLOR_W  upstream pixel for the current (X,Y), sampled on a CE tick
HSYNC  out  1  registered horizontal sync, polarity H_SYNC_POL
VSYNC  out  1  registered vertical sync, polarity V_SYNC_POL
COLOR  out  COLOR_W  registered pixel; 0 outside the active area
PIXEL_EN  out  1  combinational: CE & h_cnt<H_DISPLAY & v_cnt<V_DISPLAY
X  out  HW  current h_cnt; meaningful while PIXEL_EN=1
Y  out  VW  current v_cnt; meaningful while PIXEL_EN=1
LINE_START  out  1  combinational: CE & h_cnt==0
FRAME_START  out  1  combinational: CE & h_cnt==0 & v_cnt==0

Behaviour:
- Reset (synchronous, RESET=1 at a CLK edge):
  - h_cnt=0, v_cnt=0, COLOR=0.
  - HSYNC=~H_SYNC_POL and VSYNC=~V_SYNC_POL (inactive).
  - RESET has priority over CE. Mid-frame reset restarts at (0,0); the first tick after release yields FRAME_START.
- h_cnt: on a CE tick, increments, wrapping at H_TOTAL-1 to 0.
- v_cnt: increments only on a CE tick where h_cnt==H_TOTAL-1, wrapping at V_TOTAL-1 to 0.
- Regions (h): display [0,H_DISPLAY); front porch; sync [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC); back porch. Vertical regions use the same scheme on v_cnt.
- Output registers update on CE ticks only and hold while CE=0:
  - HSYNC <= in_hsync ? H_SYNC_POL : ~H_SYNC_POL; VSYNC likewise.
  - COLOR <= active ? PIXEL : 0.
- Latency: the counter state at tick t appears on HSYNC/VSYNC/COLOR after tick t, i.e. 1 CE tick. Sync and colour are mutually aligned. PIXEL_EN/X/Y/strobes lead the registered outputs by exactly 1 tick.
- Upstream contract: PIXEL must be valid combinationally in the same cycle PIXEL_EN=1. Upstream advances its read pointer on PIXEL_EN.
- CE=0: PIXEL_EN, LINE_START and FRAME_START are forced 0; nothing changes.
- Any zero-valued porch parameter is legal; only H_DISPLAY, H_SYNC, V_DISPLAY and V_SYNC must be ≥1. Elaboration fails ($error) otherwise.
- Counter compares use HW/VW-bit unsigned arithmetic; no overflow past TOTAL-1.

Decomposition:
- Package vga_pkg: region-decode helper functions and a default-timing localparam set (640x480@60). A typedef for the timing tuple is optional.
- One sub-module, vga_axis_counter:
  - Parameters: DISPLAY, FRONT, SYNC, BACK.
  - Ports: CLK, RESET, CE → CNT, ACTIVE, IN_SYNC, WRAP.
  - Instantiated twice: the H instance with CE; the V instance with CE = H.WRAP & CE.
- The top adds output registers, polarity and strobes.

Test Plan:
- Small timing (H 8/1/2/1, V 8/1/2/1, CE=1, pols 0), RESET pulse → after release: HSYNC=1, VSYNC=1, COLOR=0; FRAME_START=1 on the first cycle; X=0, Y=0.
- Same config, PIXEL=X+8*Y → PIXEL_EN high for X 0..7 of rows 0..7. COLOR shows 0..63 delayed 1 cycle and is 0 elsewhere. HSYNC low for 2 cycles, starting the cycle after h_cnt=9. Line period = 12 cycles.
- Vertical → VSYNC low for exactly 24 cycles (lines 9–10). FRAME_START period = 144 cycles. Y wraps 11→0.
- CE toggling 1-0-1-0 → all outputs hold on CE=0 cycles. Frame period = 288 CLK. PIXEL_EN never high while CE=0.
- Reset asserted at h_cnt=5, v_cnt=3 with CE=1 → next cycle counters (0,0), HSYNC=VSYNC=inactive, COLOR=0. RESET held with CE=1 keeps the state frozen.
- H_SYNC_POL=1, V_SYNC_POL=1, 640x480 defaults → HSYNC high for 96 ticks per 800. VSYNC high for 2 lines per 525. First HSYNC rising edge occurs one tick after h_cnt=656.
